// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low 7-segment bus: rebuilds the hex nibble per digit.
// Optional decimal-point capture is enabled by defining SEG7_DEC_DP_EN.
module seg7_scan_decoder #(
  parameter int DIGITS = 8,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  upd_valid,
  output logic [2:0]            upd_idx,
  output logic                  frame_done
`ifdef SEG7_DEC_DP_EN
  ,
  output logic [DIGITS-1:0]     dp
`endif
);

`ifdef SEG7_DEC_DP_EN
  localparam int SEGW = 8;
  logic [DIGITS+SEGW-1:0] samp;
  assign samp = {an_in, seg_in};
`else
  // dp bit is dropped from the sample so a dp flicker never restarts the counter
  localparam int SEGW = 7;
  logic [DIGITS+SEGW-1:0] samp;
  logic                   unused_dp;
  assign samp      = {an_in, seg_in[7:1]};
  assign unused_dp = seg_in[0];
`endif

  localparam int CW = (STABLE > 2) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE - 1);

  logic [DIGITS+SEGW-1:0] s_q;
  logic [CW-1:0]          cnt;
  logic                   done;
  logic [DIGITS-1:0]      seen;

  logic [DIGITS-1:0] an_q;
  logic [6:0]        segs_q;
  logic [3:0]        zcnt;
  logic [2:0]        idx;
  logic              legal;
  logic              cap;
  logic [DIGITS-1:0] cap_mask;
  logic [3:0]        dec_nib;
  logic              dec_blank;
  logic              dec_err;

  assign an_q   = s_q[DIGITS+SEGW-1 -: DIGITS];
  assign segs_q = s_q[SEGW-1 -: 7];

  always_comb begin
    zcnt = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        zcnt = zcnt + 4'd1;
        idx  = 3'(i);
      end
    end
    legal    = (zcnt == 4'd1);
    cap      = (cnt == CMAX) && !done && legal;
    cap_mask = cap ? ~an_q : '0;
  end

  always_comb begin
    dec_nib   = '0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case ({segs_q, 1'b0})
      8'h02: dec_nib = 4'h0;
      8'h9E: dec_nib = 4'h1;
      8'h24: dec_nib = 4'h2;
      8'h0C: dec_nib = 4'h3;
      8'h98: dec_nib = 4'h4;
      8'h48: dec_nib = 4'h5;
      8'h40: dec_nib = 4'h6;
      8'h1E: dec_nib = 4'h7;
      8'h00: dec_nib = 4'h8;
      8'h08: dec_nib = 4'h9;
      8'h10: dec_nib = 4'hA;
      8'hC0: dec_nib = 4'hB;
      8'h62: dec_nib = 4'hC;
      8'h84: dec_nib = 4'hD;
      8'h60: dec_nib = 4'hE;
      8'h70: dec_nib = 4'hF;
      8'hFE: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      seen       <= '0;
      value      <= '0;
      blank      <= '1;
      err        <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      frame_done <= 1'b0;
`ifdef SEG7_DEC_DP_EN
      dp         <= '0;
`endif
    end else begin
      s_q        <= samp;
      upd_valid  <= 1'b0;
      frame_done <= 1'b0;

      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (cap_mask[i]) begin
          value[4*i +: 4] <= dec_nib;
          blank[i]        <= dec_blank;
          err[i]          <= dec_err;
`ifdef SEG7_DEC_DP_EN
          dp[i]           <= ~s_q[0];
`endif
        end
      end

      if (cap) begin
        upd_valid <= 1'b1;
        upd_idx   <= idx;
        done      <= 1'b1;
      end

      // a sample change overrides the capture-done set: new interval, new capture
      if (samp != s_q) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (cnt != CMAX) begin
        cnt <= cnt + 1'b1;
      end

      if (&seen) begin
        frame_done <= 1'b1;
        seen       <= cap_mask;
      end else begin
        seen <= seen | cap_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=8, STABLE=4); dp checks apply when SEG7_DEC_DP_EN is defined.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] value;
  logic [7:0]  blank;
  logic [7:0]  err;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic        frame_done;
`ifdef SEG7_DEC_DP_EN
  logic [7:0]  dp;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n_upd = 0;
  int unsigned n_frm = 0;
  int unsigned u0, f0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(8), .STABLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .value      (value),
    .blank      (blank),
    .err        (err),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .frame_done (frame_done)
`ifdef SEG7_DEC_DP_EN
    ,
    .dp         (dp)
`endif
  );

  // pulse counters sample shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (upd_valid === 1'b1) n_upd++;
    if (frame_done === 1'b1) n_frm++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [3:0] n);
    case (n)
      4'h0: pat = 8'h02;  4'h1: pat = 8'h9E;  4'h2: pat = 8'h24;  4'h3: pat = 8'h0C;
      4'h4: pat = 8'h98;  4'h5: pat = 8'h48;  4'h6: pat = 8'h40;  4'h7: pat = 8'h1E;
      4'h8: pat = 8'h00;  4'h9: pat = 8'h08;  4'hA: pat = 8'h10;  4'hB: pat = 8'hC0;
      4'hC: pat = 8'h62;  4'hD: pat = 8'h84;  4'hE: pat = 8'h60;  default: pat = 8'h70;
    endcase
  endfunction

  task automatic hold(input logic [7:0] an, input logic [7:0] sg, input int unsigned n);
    an_in  = an;
    seg_in = sg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    an_in  = 8'hFF;
    seg_in = 8'hFF;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_value", value, 32'h0);
    check("rst_blank", {24'h0, blank}, 32'hFF);
    check("rst_err", {24'h0, err}, 32'h0);
    check("rst_upd", {31'h0, upd_valid}, 32'h0);
    check("rst_idx", {29'h0, upd_idx}, 32'h0);
    check("rst_frame", {31'h0, frame_done}, 32'h0);
`ifdef SEG7_DEC_DP_EN
    check("rst_dp", {24'h0, dp}, 32'h0);
`endif
    rst_n = 1'b1;
    hold(8'hFF, 8'hFF, 6);
    check("idle_upd_cnt", n_upd, 32'd0);
    check("idle_blank", {24'h0, blank}, 32'hFF);

    // single capture with exact latency
    u0 = n_upd;
    hold(8'hFE, 8'h24, 4);
    check("lat_early", {31'h0, upd_valid}, 32'h0);
    @(negedge clk);
    check("lat_pulse", {31'h0, upd_valid}, 32'h1);
    check("lat_idx", {29'h0, upd_idx}, 32'h0);
    check("lat_nib0", {28'h0, value[3:0]}, 32'h2);
    check("lat_blank0", {31'h0, blank[0]}, 32'h0);
    @(negedge clk);
    check("pulse_width", {31'h0, upd_valid}, 32'h0);
    check("one_capture", n_upd - u0, 32'd1);

    // full scan 0..7
    u0 = n_upd;
    f0 = n_frm;
    for (int d = 0; d < 8; d++) begin
      hold(~(8'h01 << d), pat(4'(d)), 6);
      if (d == 6) check("frame_early", n_frm - f0, 32'd0);
    end
    check("scan_frame", n_frm - f0, 32'd1);
    check("scan_upds", n_upd - u0, 32'd8);
    check("scan_value", value, 32'h76543210);
    check("scan_err", {24'h0, err}, 32'h0);
    check("scan_blank", {24'h0, blank}, 32'h0);
    check("scan_idx", {29'h0, upd_idx}, 32'h7);

    // blank and error patterns on digit 3; other digits hold
    hold(8'hF7, 8'hFE, 6);
    check("blank3", {31'h0, blank[3]}, 32'h1);
    check("blank3_err", {31'h0, err[3]}, 32'h0);
    check("blank3_value", value, 32'h76540210);
    u0 = n_upd;
    hold(8'hF7, 8'hFF, 6);
`ifdef SEG7_DEC_DP_EN
    check("dp_change_capt", n_upd - u0, 32'd1);
    check("dp3_off", {31'h0, dp[3]}, 32'h0);
`else
    check("dp_change_ign", n_upd - u0, 32'd0);
`endif
    check("ff_blank3", {31'h0, blank[3]}, 32'h1);
    hold(8'hF7, 8'hFC, 6);
    check("err3", {31'h0, err[3]}, 32'h1);
    check("err3_blank", {31'h0, blank[3]}, 32'h0);
    check("err3_value", value, 32'h76540210);
    hold(8'hF7, 8'h0C, 6);
    check("err3_clear", {31'h0, err[3]}, 32'h0);
    check("hex3_value", value, 32'h76543210);

    // glitching segments and illegal selects never capture
    u0 = n_upd;
    for (int k = 0; k < 6; k++) hold(8'hFD, (k % 2 == 1) ? 8'h98 : 8'h0C, 3);
    check("glitch_nocap", n_upd - u0, 32'd0);
    hold(8'hFC, 8'h02, 8);
    hold(8'hFF, 8'h02, 8);
    check("illegal_nocap", n_upd - u0, 32'd0);
    check("illegal_value", value, 32'h76543210);

`ifndef SEG7_DEC_DP_EN
    // dp flicker alone does not restart the stability count
    u0 = n_upd;
    for (int k = 0; k < 4; k++) hold(8'hFB, (k % 2 == 1) ? 8'h99 : 8'h98, 2);
    check("dpflick_cap", n_upd - u0, 32'd1);
    check("dpflick_value", value, 32'h76543410);
`endif

    // reset mid-frame, then rescan in reverse order
    for (int d = 0; d < 5; d++) hold(~(8'h01 << d), pat(4'(d + 8)), 6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_value", value, 32'h0);
    check("midrst_blank", {24'h0, blank}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = n_frm;
    for (int j = 0; j < 8; j++) begin
      hold(~(8'h01 << (7 - j)), pat(4'(8 + j)), 6);
      if (j == 6) check("rescan_early", n_frm - f0, 32'd0);
    end
    check("rescan_frame", n_frm - f0, 32'd1);
    check("rescan_value", value, 32'h89ABCDEF);

`ifdef SEG7_DEC_DP_EN
    hold(8'hFD, 8'h0C, 6);
    check("dp1_lit", {31'h0, dp[1]}, 32'h1);
    check("dp1_value", {28'h0, value[7:4]}, 32'h3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
